// File: rtl/zest_amc7823_pkg.sv
// Shared constants for the AMC7823 poller: FSM encoding and command-word helpers.
package zest_amc7823_pkg;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_PERIOD = 3'd1;
  localparam logic [2:0] ST_START       = 3'd2;
  localparam logic [2:0] ST_WAIT_LOW    = 3'd3;
  localparam logic [2:0] ST_WAIT_HIGH   = 3'd4;

  // Command word: bit 15 selects read, page sits at bits 13:12, register address below.
  localparam logic [15:0] AMC_RW_READ  = 16'h8000;
  localparam logic [15:0] AMC_RW_WRITE = 16'h0000;
  localparam int          AMC_PAGE_LSB = 12;
  localparam logic [1:0]  AMC_PAGE_ADC = 2'd0;

  function automatic logic [15:0] amc_cmd(input logic rd, input logic [1:0] page,
                                          input logic [11:0] addr);
    amc_cmd = (rd ? AMC_RW_READ : AMC_RW_WRITE) | ({14'd0, page} << AMC_PAGE_LSB) | {4'd0, addr};
  endfunction

  localparam logic [15:0] READ_CMD_BASE_DEFAULT = amc_cmd(1'b1, AMC_PAGE_ADC, 12'h000);

endpackage

// File: rtl/zest_amc7823_shadow.sv
// Channel shadow register file: one write port, registered read port, cleared by reset.
module zest_amc7823_shadow #(
  parameter int N_CH  = 8,
  parameter int CH_AW = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [CH_AW-1:0] wr_addr_i,
  input  logic [15:0]      wr_data_i,
  input  logic [CH_AW-1:0] rd_addr_i,
  output logic [15:0]      rd_data_o
);

  logic [15:0] mem_q [N_CH];
  logic [15:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (32'(wr_addr_i) < N_CH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Addresses beyond N_CH read as zero when N_CH is not a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (32'(rd_addr_i) < N_CH) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/zest_amc7823_poller.sv
// Sequencer in front of the AMC7823 SPI engine: periodic channel sweeps into a shadow
// register file, with single host register writes interleaved at transaction boundaries.
module zest_amc7823_poller
  import zest_amc7823_pkg::*;
#(
  parameter int          N_CH          = 8,
  parameter int          CH_AW         = 3,
  parameter logic [15:0] READ_CMD_BASE = READ_CMD_BASE_DEFAULT,
  parameter int          TIMEOUT       = 4095,
  parameter int          PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                host_wr_stb,
  input  logic [15:0]         host_wr_addr,
  input  logic [15:0]         host_wr_data,
  output logic                host_wr_busy,
  input  logic [CH_AW-1:0]    rd_addr,
  output logic [15:0]         rd_data,
  output logic [15:0]         sweep_count,
  output logic                timeout_err,
  output logic                spi_clk,
  output logic                spi_start,
  output logic [15:0]         spi_addr,
  output logic                spi_read,
  output logic [15:0]         spi_data,
  input  logic                spi_ready,
  input  logic [15:0]         spi_rdbk
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [2:0]          state_q, state_d;
  logic [CH_AW-1:0]    ch_q, ch_d;
  logic [PERIOD_W-1:0] per_cnt_q, per_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                pend_q, pend_d;
  logic [15:0]         hw_addr_q, hw_addr_d;
  logic [15:0]         hw_data_q, hw_data_d;
  logic                is_wr_q, is_wr_d;
  logic                spi_start_q, spi_start_d;
  logic [15:0]         spi_addr_q, spi_addr_d;
  logic                spi_read_q, spi_read_d;
  logic [15:0]         spi_data_q, spi_data_d;
  logic [15:0]         sweep_q, sweep_d;
  logic                terr_q, terr_d;
  logic                sh_we;
  logic                to_expired;

  assign to_expired = (32'(to_cnt_q) >= TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    per_cnt_d   = per_cnt_q;
    to_cnt_d    = to_cnt_q;
    pend_d      = pend_q;
    hw_addr_d   = hw_addr_q;
    hw_data_d   = hw_data_q;
    is_wr_d     = is_wr_q;
    spi_start_d = 1'b0;
    spi_addr_d  = spi_addr_q;
    spi_read_d  = spi_read_q;
    spi_data_d  = spi_data_q;
    sweep_d     = sweep_q;
    terr_d      = terr_q;
    sh_we       = 1'b0;

    if (host_wr_stb && !pend_q) begin
      pend_d    = 1'b1;
      hw_addr_d = host_wr_addr;
      hw_data_d = host_wr_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (spi_ready && pend_q) begin
          spi_addr_d  = hw_addr_q;
          spi_data_d  = hw_data_q;
          spi_read_d  = 1'b0;
          is_wr_d     = 1'b1;
          spi_start_d = 1'b1;
          state_d     = ST_START;
        end else if (spi_ready && enable) begin
          spi_addr_d  = READ_CMD_BASE + 16'(ch_q);
          spi_read_d  = 1'b1;
          is_wr_d     = 1'b0;
          spi_start_d = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT_LOW;
      end
      ST_WAIT_LOW, ST_WAIT_HIGH: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == ST_WAIT_LOW && !spi_ready) begin
          state_d = ST_WAIT_HIGH;
        end else if (state_q == ST_WAIT_HIGH && spi_ready) begin
          if (is_wr_q) begin
            pend_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            sh_we = 1'b1;
            if (ch_q == CH_AW'(N_CH - 1)) begin
              ch_d      = '0;
              sweep_d   = sweep_q + 16'd1;
              per_cnt_d = '0;
              state_d   = ST_WAIT_PERIOD;
            end else begin
              ch_d    = ch_q + 1'b1;
              state_d = ST_IDLE;
            end
          end
        end else if (to_expired) begin
          // Abort: a read keeps ch so it is retried, a write is dropped.
          terr_d  = 1'b1;
          state_d = ST_IDLE;
          if (is_wr_q) pend_d = 1'b0;
        end
      end
      ST_WAIT_PERIOD: begin
        if (pend_q || !enable || (per_cnt_q >= period)) begin
          state_d = ST_IDLE;
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      per_cnt_q   <= '0;
      to_cnt_q    <= '0;
      pend_q      <= 1'b0;
      hw_addr_q   <= '0;
      hw_data_q   <= '0;
      is_wr_q     <= 1'b0;
      spi_start_q <= 1'b0;
      spi_addr_q  <= '0;
      spi_read_q  <= 1'b1;
      spi_data_q  <= '0;
      sweep_q     <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      per_cnt_q   <= per_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pend_q      <= pend_d;
      hw_addr_q   <= hw_addr_d;
      hw_data_q   <= hw_data_d;
      is_wr_q     <= is_wr_d;
      spi_start_q <= spi_start_d;
      spi_addr_q  <= spi_addr_d;
      spi_read_q  <= spi_read_d;
      spi_data_q  <= spi_data_d;
      sweep_q     <= sweep_d;
      terr_q      <= terr_d;
    end
  end

  zest_amc7823_shadow #(
    .N_CH  (N_CH),
    .CH_AW (CH_AW)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (sh_we),
    .wr_addr_i (ch_q),
    .wr_data_i (spi_rdbk),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  // Gate the strobe so the engine never sees a start while reset is held.
  assign spi_start    = spi_start_q & ~rst;
  assign spi_clk      = clk;
  assign spi_addr     = spi_addr_q;
  assign spi_read     = spi_read_q;
  assign spi_data     = spi_data_q;
  assign host_wr_busy = pend_q;
  assign sweep_count  = sweep_q;
  assign timeout_err  = terr_q;

endmodule
